// File: rtl/jacobi_rotate.sv
// jacobi_rotate: applies one Jacobi (Givens) similarity rotation to a symmetric NxN Q7.8 matrix.
// Build macro JACOBI_ROUND_EN: round half up before every CS_FRAC shift (default: truncate).
module jacobi_rotate #(
  parameter int unsigned N_STOCKS  = 3,
  parameter int unsigned IDX_W     = 4,
  parameter int unsigned FRAC_BITS = 8,
  parameter int unsigned CS_FRAC   = 14
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [N_STOCKS-1:0][N_STOCKS-1:0][15:0] matrix,
  input  logic [IDX_W-1:0]                        pivot_i,
  input  logic [IDX_W-1:0]                        pivot_j,
  input  logic signed [15:0]                      cos_t,
  input  logic signed [15:0]                      sin_t,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [N_STOCKS-1:0][N_STOCKS-1:0][15:0] out_matrix,
  output logic                                    err
);

  localparam int unsigned ELEM_W = 16;
  localparam int unsigned ACC_W  = 36;
  localparam int unsigned K_W    = (N_STOCKS > 1) ? $clog2(N_STOCKS) : 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(32768);
`ifdef JACOBI_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (CS_FRAC - 1);
`else
  localparam logic signed [ACC_W-1:0] RND = '0;
`endif

  if (FRAC_BITS >= ELEM_W || CS_FRAC == 0 || CS_FRAC >= ELEM_W) begin : g_bad_params
    $error("jacobi_rotate: unsupported FRAC_BITS/CS_FRAC");
  end

  typedef logic [N_STOCKS-1:0][N_STOCKS-1:0][ELEM_W-1:0] mat_t;
  typedef enum logic [2:0] {IDLE, ROW, DIAG1, DIAG2, DONE} state_t;

  // Full-precision signed product, sign-extended into the accumulator width.
  function automatic logic signed [ACC_W-1:0] mul(input logic signed [ELEM_W-1:0] a,
                                                  input logic signed [ELEM_W-1:0] b);
    return ACC_W'(a) * ACC_W'(b);
  endfunction

  // Optional rounding, arithmetic shift by CS_FRAC, then clamp to 16-bit signed.
  function automatic logic [ELEM_W-1:0] shift_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] sh;
    sh = (acc + RND) >>> CS_FRAC;
    if (sh > SAT_MAX)      return 16'h7fff;
    else if (sh < SAT_MIN) return 16'h8000;
    else                   return ELEM_W'(sh);
  endfunction

  state_t                    state_q, state_d;
  logic [K_W-1:0]            k_q, k_d;
  logic [K_W-1:0]            p_q, p_d;
  logic [K_W-1:0]            q_q, q_d;
  logic                      bad_q, bad_d;
  logic signed [ELEM_W-1:0]  c_q, c_d;
  logic signed [ELEM_W-1:0]  s_q, s_d;
  logic signed [ELEM_W-1:0]  cc_q, cc_d;
  logic signed [ELEM_W-1:0]  ss_q, ss_d;
  logic signed [ELEM_W-1:0]  sc_q, sc_d;
  logic                      step_q, step_d;
  logic signed [ACC_W-1:0]   pp_acc_q, pp_acc_d;
  logic signed [ACC_W-1:0]   qq_acc_q, qq_acc_d;
  mat_t                      work_q, work_d;
  logic                      out_valid_q, out_valid_d;
  logic                      err_q, err_d;

  logic [IDX_W-1:0]          lo, hi;
  logic signed [ELEM_W-1:0]  a_kp, a_kq, a_pp, a_pq, a_qq;
  logic [ELEM_W-1:0]         new_kp, new_kq;

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = out_valid_q;
  assign err        = err_q;
  assign out_matrix = work_q;

  // Next-state and datapath: one row/column pair per ROW cycle, then the 2x2 diagonal block.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    p_d         = p_q;
    q_d         = q_q;
    bad_d       = bad_q;
    c_d         = c_q;
    s_d         = s_q;
    cc_d        = cc_q;
    ss_d        = ss_q;
    sc_d        = sc_q;
    step_d      = step_q;
    pp_acc_d    = pp_acc_q;
    qq_acc_d    = qq_acc_q;
    work_d      = work_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;

    lo = pivot_i;
    hi = pivot_j;
    if (pivot_i > pivot_j) begin
      lo = pivot_j;
      hi = pivot_i;
    end

    a_kp   = work_q[k_q][p_q];
    a_kq   = work_q[k_q][q_q];
    a_pp   = work_q[p_q][p_q];
    a_pq   = work_q[p_q][q_q];
    a_qq   = work_q[q_q][q_q];
    new_kp = shift_sat(mul(c_q, a_kp) - mul(s_q, a_kq));
    new_kq = shift_sat(mul(s_q, a_kp) + mul(c_q, a_kq));

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = matrix;
          c_d     = cos_t;
          s_d     = sin_t;
          p_d     = K_W'(lo);
          q_d     = K_W'(hi);
          bad_d   = (pivot_i == pivot_j) || (32'(pivot_i) >= N_STOCKS) ||
                    (32'(pivot_j) >= N_STOCKS);
          k_d     = '0;
          state_d = ROW;
        end
      end
      ROW: begin
        if (bad_q) begin
          out_valid_d = 1'b1;
          err_d       = 1'b1;
          state_d     = DONE;
        end else begin
          // Pivot rows are no-op cycles so latency does not depend on (p, q).
          if (k_q != p_q && k_q != q_q) begin
            work_d[k_q][p_q] = new_kp;
            work_d[p_q][k_q] = new_kp;
            work_d[k_q][q_q] = new_kq;
            work_d[q_q][k_q] = new_kq;
          end
          if (k_q == K_W'(N_STOCKS - 1)) state_d = DIAG1;
          else                           k_d     = k_q + K_W'(1);
        end
      end
      DIAG1: begin
        cc_d    = shift_sat(mul(c_q, c_q));
        ss_d    = shift_sat(mul(s_q, s_q));
        sc_d    = shift_sat(mul(s_q, c_q));
        step_d  = 1'b0;
        state_d = DIAG2;
      end
      DIAG2: begin
        // Step 0 accumulates the products; step 1 shifts, saturates and writes back.
        if (!step_q) begin
          pp_acc_d = mul(cc_q, a_pp) - (mul(sc_q, a_pq) <<< 1) + mul(ss_q, a_qq);
          qq_acc_d = mul(ss_q, a_pp) + (mul(sc_q, a_pq) <<< 1) + mul(cc_q, a_qq);
          step_d   = 1'b1;
        end else begin
          work_d[p_q][p_q] = shift_sat(pp_acc_q);
          work_d[q_q][q_q] = shift_sat(qq_acc_q);
          work_d[p_q][q_q] = '0;
          work_d[q_q][p_q] = '0;
          out_valid_d      = 1'b1;
          err_d            = 1'b0;
          state_d          = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          err_d       = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      p_q         <= '0;
      q_q         <= '0;
      bad_q       <= 1'b0;
      c_q         <= '0;
      s_q         <= '0;
      cc_q        <= '0;
      ss_q        <= '0;
      sc_q        <= '0;
      step_q      <= 1'b0;
      pp_acc_q    <= '0;
      qq_acc_q    <= '0;
      work_q      <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      p_q         <= p_d;
      q_q         <= q_d;
      bad_q       <= bad_d;
      c_q         <= c_d;
      s_q         <= s_d;
      cc_q        <= cc_d;
      ss_q        <= ss_d;
      sc_q        <= sc_d;
      step_q      <= step_d;
      pp_acc_q    <= pp_acc_d;
      qq_acc_q    <= qq_acc_d;
      work_q      <= work_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_jacobi_rotate.sv
// tb_jacobi_rotate: directed and random jobs against an integer model of the rotation.
module tb_jacobi_rotate;
  localparam int N   = 3;
  localparam int CSF = 14;
  localparam int MW  = N * N * 16;
`ifdef JACOBI_ROUND_EN
  localparam longint RND = 64'sd8192;
`else
  localparam longint RND = 64'sd0;
`endif

  typedef logic [N-1:0][N-1:0][15:0] mat_t;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, err;
  mat_t        matrix, out_matrix;
  logic [3:0]  pivot_i, pivot_j;
  logic [15:0] cos_t, sin_t;
  int          n_checks = 0;
  int          n_fail = 0;

  jacobi_rotate dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .matrix(matrix), .pivot_i(pivot_i), .pivot_j(pivot_j),
    .cos_t(cos_t), .sin_t(sin_t), .out_valid(out_valid), .out_ready(out_ready),
    .out_matrix(out_matrix), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint sat16(input longint x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic longint rs(input longint x);
    return (x + RND) >>> CSF;
  endfunction

  function automatic bit is_bad(input int pi, input int pj);
    return (pi == pj) || (pi >= N) || (pj >= N);
  endfunction

  // Reference rotation from the mathematical definition on integer copies of A.
  function automatic mat_t model(input mat_t a, input int pi, input int pj, input int c, input int s);
    longint m[N][N];
    longint r[N][N];
    longint cc, ss, sc;
    int     p, q;
    mat_t   res;
    if (is_bad(pi, pj)) return a;
    p = (pi < pj) ? pi : pj;
    q = (pi < pj) ? pj : pi;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        m[i][j] = longint'($signed(a[i][j]));
        r[i][j] = m[i][j];
      end
    for (int k = 0; k < N; k++)
      if (k != p && k != q) begin
        r[k][p] = sat16(rs(c * m[k][p] - s * m[k][q]));
        r[p][k] = r[k][p];
        r[k][q] = sat16(rs(s * m[k][p] + c * m[k][q]));
        r[q][k] = r[k][q];
      end
    cc = sat16(rs(longint'(c) * c));
    ss = sat16(rs(longint'(s) * s));
    sc = sat16(rs(longint'(s) * c));
    r[p][p] = sat16(rs(cc * m[p][p] - 2 * sc * m[p][q] + ss * m[q][q]));
    r[q][q] = sat16(rs(ss * m[p][p] + 2 * sc * m[p][q] + cc * m[q][q]));
    r[p][q] = 0;
    r[q][p] = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) res[i][j] = 16'(r[i][j]);
    return res;
  endfunction

  function automatic mat_t mk(input int a00, input int a01, input int a02,
                              input int a11, input int a12, input int a22);
    mat_t m;
    m[0][0] = 16'(a00); m[0][1] = 16'(a01); m[0][2] = 16'(a02);
    m[1][0] = 16'(a01); m[1][1] = 16'(a11); m[1][2] = 16'(a12);
    m[2][0] = 16'(a02); m[2][1] = 16'(a12); m[2][2] = 16'(a22);
    return m;
  endfunction

  task automatic drive_job(input mat_t a, input int pi, input int pj, input int c, input int s);
    matrix   = a;
    pivot_i  = 4'(pi);
    pivot_j  = 4'(pj);
    cos_t    = 16'(c);
    sin_t    = 16'(s);
    in_valid = 1'b1;
  endtask

  task automatic accept(input string tag);
    check({tag, "_in_ready"}, MW'(in_ready), MW'(1'b1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic await_result(input string tag, input mat_t a, input int pi, input int pj,
                              input int c, input int s);
    int   edges;
    bit   bad;
    mat_t exp;
    edges = 0;
    bad   = is_bad(pi, pj);
    exp   = model(a, pi, pj, c, s);
    while (!out_valid && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check({tag, "_latency"}, MW'(edges), MW'(bad ? 1 : N + 3));
    check({tag, "_matrix"}, MW'(out_matrix), MW'(exp));
    check({tag, "_err"}, MW'(err), MW'(bad));
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_ov_clr"}, MW'(out_valid), MW'(1'b0));
    check({tag, "_err_clr"}, MW'(err), MW'(1'b0));
    check({tag, "_idle"}, MW'(in_ready), MW'(1'b1));
  endtask

  task automatic run_job(input string tag, input mat_t a, input int pi, input int pj,
                         input int c, input int s);
    drive_job(a, pi, pj, c, s);
    accept(tag);
    await_result(tag, a, pi, pj, c, s);
    release_result(tag);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    mat_t a, a90, b, hold;
    logic [15:0] r16;
    int pi, pj, c, s;

    a   = mk(768, 256, 0, 768, 0, 1024);
    a90 = mk(768, 256, 0, 768, -32768, 1024);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    matrix = '0; pivot_i = '0; pivot_j = '0; cos_t = '0; sin_t = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", MW'(out_valid), MW'(1'b0));
    check("rst_err", MW'(err), MW'(1'b0));
    check("rst_matrix", MW'(out_matrix), MW'(0));
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", MW'(in_ready), MW'(1'b1));

    run_job("identity", a, 0, 1, 16384, 0);

    // 45 degrees, with hand-derived element values.
    drive_job(a, 0, 1, 11585, 11585);
    accept("deg45");
    await_result("deg45", a, 0, 1, 11585, 11585);
`ifdef JACOBI_ROUND_EN
    check("deg45_a00", MW'(out_matrix[0][0]), MW'(16'd512));
    check("deg45_a11", MW'(out_matrix[1][1]), MW'(16'd1024));
`else
    check("deg45_a00", MW'(out_matrix[0][0]), MW'(16'd511));
    check("deg45_a11", MW'(out_matrix[1][1]), MW'(16'd1023));
`endif
    check("deg45_a22", MW'(out_matrix[2][2]), MW'(16'd1024));
    check("deg45_a01", MW'({out_matrix[0][1], out_matrix[1][0]}), MW'(0));
    check("deg45_a02_a12", MW'({out_matrix[0][2], out_matrix[1][2]}), MW'(0));
    release_result("deg45");

    // 90 degrees: -a12 overflows and must clamp; diagonals swap.
    drive_job(a90, 0, 2, 0, 16384);
    accept("deg90");
    await_result("deg90", a90, 0, 2, 0, 16384);
    check("deg90_a10_sat", MW'(out_matrix[1][0]), MW'(16'd32767));
    check("deg90_a00", MW'(out_matrix[0][0]), MW'(16'd1024));
    check("deg90_a22", MW'(out_matrix[2][2]), MW'(16'd768));
    release_result("deg90");

    // Swapped pivot order yields the p<q result.
    drive_job(a, 1, 0, 11585, 11585);
    accept("swap");
    await_result("swap", a, 1, 0, 11585, 11585);
`ifdef JACOBI_ROUND_EN
    check("swap_a00", MW'(out_matrix[0][0]), MW'(16'd512));
`else
    check("swap_a00", MW'(out_matrix[0][0]), MW'(16'd511));
`endif
    release_result("swap");

    run_job("inv_eq", a, 1, 1, 11585, 11585);
    run_job("inv_range", a, 0, 5, 11585, 11585);

    // Backpressure with a competing upstream job.
    b = mk(100, -200, 300, -400, 500, 600);
    drive_job(a, 0, 1, 11585, 11585);
    accept("bp");
    await_result("bp", a, 0, 1, 11585, 11585);
    hold = model(a, 0, 1, 11585, 11585);
    drive_job(b, 0, 2, 15137, -6270);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_in_ready_low", MW'(in_ready), MW'(1'b0));
      check("bp_out_valid_held", MW'(out_valid), MW'(1'b1));
      check("bp_matrix_held", MW'(out_matrix), MW'(hold));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_idle", MW'(in_ready), MW'(1'b1));
    check("bp_release_ov", MW'(out_valid), MW'(1'b0));
    accept("bp_next");
    await_result("bp_next", b, 0, 2, 15137, -6270);
    release_result("bp_next");

    // Reset while ROW is at k=1.
    drive_job(a, 0, 2, 11585, 11585);
    accept("midrst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_out_valid", MW'(out_valid), MW'(1'b0));
    check("midrst_err", MW'(err), MW'(1'b0));
    check("midrst_matrix", MW'(out_matrix), MW'(0));
    check("midrst_in_ready", MW'(in_ready), MW'(1'b1));
    run_job("after_rst", b, 2, 1, 11585, -11585);

    // Random symmetric matrices, pivots (including invalid) and cos/sin.
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < N; i++)
        for (int j = i; j < N; j++) begin
          r16 = (t % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 4095) - 2048);
          b[i][j] = r16;
          b[j][i] = r16;
        end
      pi = $urandom_range(0, 4);
      pj = $urandom_range(0, 4);
      r16 = 16'($urandom);
      c = int'($signed(r16));
      r16 = 16'($urandom);
      s = int'($signed(r16));
      drive_job(b, pi, pj, c, s);
      accept("rand");
      await_result("rand", b, pi, pj, c, s);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      release_result("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/jacobi_rotate.md
Name: jacobi_rotate

Overview:
- Sequential consumer of the pivot finder's (pivot_i, pivot_j) output.
- Applies one Jacobi (Givens) similarity rotation to a symmetric NxN signed fixed-point matrix, given the pivot pair (p, q) and precomputed cos/sin.
- Returns the rotated matrix with a'pq = a'qp = 0, ready to feed back into the pivot finder for the next sweep.
- Uses one row/column pair per cycle, with valid/ready on both input and output.

Parameters:
- N_STOCKS, 3, matrix dimension N.
- IDX_W, 4, width of pivot index ports.
- FRAC_BITS, 8, fractional bits of matrix elements (Q7.8, 16-bit signed).
- CS_FRAC, 14, fractional bits of cos/sin (Q1.14, 16-bit signed).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input job valid.
- in_ready  out  1  block idle, can accept a job.
- matrix  in  N*N*16  signed packed [N-1:0][N-1:0][15:0], symmetric.
- pivot_i  in  IDX_W  pivot row p.
- pivot_j  in  IDX_W  pivot column q.
- cos_t  in  16  signed cos, Q1.14.
- sin_t  in  16  signed sin, Q1.14.
- out_valid  out  1  rotated matrix valid.
- out_ready  in  1  downstream accepts result.
- out_matrix  out  N*N*16  signed packed rotated matrix, same layout as matrix.
- err  out  1  qualifies out_valid: job had an invalid pivot.

Behaviour:
Reset:
- rst_n=0 at a rising edge forces state IDLE.
- Outputs after reset: out_valid=0, err=0, out_matrix=0, in_ready=1 once reset is released.
- Reset mid-job aborts the job silently; no partial result is ever presented.

Handshake:
- in_ready = (state==IDLE), combinational from state.
- A job is accepted on the edge where in_valid && in_ready.
- On acceptance, matrix, p, q, cos_t and sin_t are latched into a working copy.
- If p>q, the indices are swapped internally; the result is identical because the matrix is symmetric.

States: IDLE -> ROW -> DIAG1 -> DIAG2 -> DONE -> IDLE.
- ROW:
  - Lasts exactly N cycles, k = 0..N-1, one k per edge.
  - For k not in {p,q}:
    - a'kp = a'pk = (c*akp - s*akq) >>> CS_FRAC
    - a'kq = a'qk = (s*akp + c*akq) >>> CS_FRAC
  - k==p or k==q is a no-op cycle, so latency is fixed.
  - ROW reads only akp and akq, which no other k modifies, so in-place update is safe.
- DIAG1:
  - Registers cc = c*c >>> CS_FRAC, ss = s*s >>> CS_FRAC, sc = s*c >>> CS_FRAC.
- DIAG2:
  - a'pp = (cc*app - 2*sc*apq + ss*aqq) >>> CS_FRAC
  - a'qq = (ss*app + 2*sc*apq + cc*aqq) >>> CS_FRAC
  - Sums are accumulated in at least 34-bit signed width before the shift.
  - apq and aqp are forced to 0.
- DONE:
  - out_valid=1; out_matrix = working copy, held stable.
  - in_ready stays 0 until out_valid && out_ready, then IDLE on the same edge.
  - out_valid can stay high indefinitely under backpressure; nothing changes meanwhile.

Arithmetic:
- All >>> are arithmetic shifts (floor toward -inf); no rounding by default.
- Every 16-bit result saturates to [-32768, 32767].

Latency:
- The accepting edge is E0; out_valid is high after edge E0+N+3.
- N edges ROW, one DIAG1, one DIAG2, then the DONE transition.

Invalid pivot:
- Condition: p==q, p>=N, or q>=N.
- Goes straight to DONE on the edge after acceptance.
- out_matrix = input matrix unchanged, err=1.
- err=0 on every valid job; err is cleared on the output handshake.

Simultaneous events:
- in_valid is ignored while not IDLE; no queueing.
- An upstream job presented during DONE is accepted only after a return to IDLE.

Optional Feature:
- Macro: JACOBI_ROUND_EN.
- Defined: every shift by CS_FRAC adds 1<<(CS_FRAC-1) before shifting (round half up), then saturates. This applies to ROW, DIAG1 and DIAG2.
- Undefined: pure truncation as specified above.
- Latency is identical in both builds.

Test Plan (N=3, Q7.8 elements, Q1.14 c/s; 1.0 = 256 for elements, 16384 for c/s):
- Identity rotation:
  - Stimulus: A=[[3,1,0],[1,3,0],[0,0,4]] (768,256,...), p=0, q=1, c=16384, s=0.
  - Required: out identical except a01=a10=0; out_valid exactly N+3 edges after accept; err=0.
- 45-degree rotation:
  - Stimulus: same A, c=s=11585.
  - Required, default build: a00=511, a11=1023, a22=1024, a01=a10=a02=a12=0.
  - Required, with JACOBI_ROUND_EN: a00=512, a11=1024.
- 90-degree rotation with saturation:
  - Stimulus: c=0, s=16384, p=0, q=2, a12=a21=-32768.
  - Required: a'10 = -a12 saturates to 32767; a00 and a22 swap values.
- Swapped and invalid pivot:
  - Stimulus 1: p=1, q=0, c=s=11585.
  - Required: same result as p=0, q=1.
  - Stimulus 2: p=q=1.
  - Required: out_valid after 1 edge, err=1, matrix unchanged.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles while presenting a new in_valid job.
  - Required: out_matrix stable, in_ready=0; after out_ready=1, in_ready=1 next cycle and the new job runs.
- Reset mid-job:
  - Stimulus: drop rst_n during ROW k=1.
  - Required: next cycle out_valid=0, err=0, out_matrix=0, in_ready=1; a following job completes correctly.
